avalon_bus_ram: RTL and testbench

//  Word-addressed RAM slave on the CPU's Avalon-style memory bus; directly downstream of mips_cpu_bus.

---
 rtl/mips_bus_pkg.sv | 23 ++
 rtl/bus_lane_swap.sv | 15 +
 rtl/avalon_bus_ram.sv | 135 +++++++++++++
 tb/tb_avalon_bus_ram.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the CPU memory bus: reset vector, slave FSM states
// and the byte-lane ordering helpers used by the RAM slave and bus monitors.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bus_state_t;

  // The CPU numbers bytes opposite to memory: bus lane n maps to word byte 3-n.
  function automatic logic [31:0] lane_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Byteenable expressed in memory-word lane order.
  function automatic logic [3:0] be_reverse(input logic [3:0] be);
    return {be[0], be[1], be[2], be[3]};
  endfunction

endpackage

// File: rtl/bus_lane_swap.sv
// Combinational byte reversal of a 32-bit word plus expansion of a 4-bit lane
// enable into a 32-bit bit mask in the same lane order as the enables.
module bus_lane_swap
  import mips_bus_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [3:0]  be_i,
  output logic [31:0] swap_o,
  output logic [31:0] mask_o
);

  assign swap_o = lane_swap(data_i);
  assign mask_o = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

endmodule

// File: rtl/avalon_bus_ram.sv
// Word-addressed RAM slave for the CPU's Avalon-style bus with a fixed number
// of wait states, per-lane writes and the CPU's reversed byte-lane ordering.
//
// Handshake: the master raises read or write with address/byteenable/writedata
// and holds them while waitrequest is high. The transfer is accepted in the
// cycle where waitrequest is low with the request still high; readdata is valid
// in that same cycle. A request still high in the following cycle starts a new
// transfer. Dropping the request while waitrequest is high abandons it.
module avalon_bus_ram
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        fault,
  output logic [1:0]  dbg_state_o
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  bus_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [DEPTH];

  logic              req;
  logic              enter_ready;
  logic              illegal;
  logic              commit;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       word;
  logic [31:0]       rd_swap, rd_mask;
  logic [31:0]       wr_swap, wr_mask;
  logic [31:0]       word_new;

  assign req         = read | write;
  assign dbg_state_o = state_q;
  assign readdata    = rdata_q;
  assign fault       = fault_q;

  // Address decode: addresses below BASE_ADDR wrap to large offsets and fail
  // the range check, so a single unsigned compare covers both bounds.
  assign offset  = address - BASE_ADDR;
  assign idx     = offset[IDX_W+1:2];
  assign word    = mem_q[idx];
  assign illegal = (address == 32'd0) || (offset >= LIMIT) ||
                   (offset[1:0] != 2'b00) || (read && write);

  // Read path: memory word into bus lane order, masked by the bus enables.
  bus_lane_swap u_rd_swap (
    .data_i (word),
    .be_i   (byteenable),
    .swap_o (rd_swap),
    .mask_o (rd_mask)
  );

  // Write path: bus data into memory lane order, enables reversed to match.
  bus_lane_swap u_wr_swap (
    .data_i (writedata),
    .be_i   (be_reverse(byteenable)),
    .swap_o (wr_swap),
    .mask_o (wr_mask)
  );

  assign word_new = (word & ~wr_mask) | (wr_swap & wr_mask);
  assign rdata_d  = illegal ? (rdata_q & ~rd_mask)
                            : ((rdata_q & ~rd_mask) | (rd_swap & rd_mask));
  assign commit   = (state_q == READY) && write && !illegal;

  // Reset forces the bus free so a master held in reset never stalls.
  always_comb begin
    waitrequest = 1'b0;
    if (!reset) waitrequest = req && (state_q != READY);
  end

  // Next-state logic: count wait cycles, then one READY (completion) cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!req)               state_d = IDLE;
        else if (cnt_q == 4'd1) state_d = READY;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_ready = (state_d == READY) && (state_q != READY);
    fault_d     = enter_ready && illegal;
  end

  // FSM state, wait counter and fault pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Memory write port and readdata capture; memory contents survive reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else begin
      if (enter_ready && read) rdata_q <= rdata_d;
      if (commit)              mem_q[idx] <= word_new;
    end
  end

endmodule

// File: tb/tb_avalon_bus_ram.sv
// Bench for avalon_bus_ram: three instances with 1, 3 and 4 wait states,
// a table of single transfers on the 1-wait instance and hand-written
// sequences for abandoned transfers, reset mid-transfer and back-to-back reads.
module tb_avalon_bus_ram;
  import mips_bus_pkg::*;

  localparam logic [31:0] B = 32'hBFC00000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd_s   [3];
  logic        wr_s   [3];
  logic [31:0] addr_s [3];
  logic [3:0]  be_s   [3];
  logic [31:0] wd_s   [3];
  logic        wreq_s [3];
  logic [31:0] rdata_s[3];
  logic        flt_s  [3];
  logic [1:0]  st_s   [3];

  int n_checks = 0;
  int n_errors = 0;

  avalon_bus_ram #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset), .read(rd_s[0]), .write(wr_s[0]), .address(addr_s[0]),
    .byteenable(be_s[0]), .writedata(wd_s[0]), .waitrequest(wreq_s[0]),
    .readdata(rdata_s[0]), .fault(flt_s[0]), .dbg_state_o(st_s[0]));

  avalon_bus_ram #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .reset(reset), .read(rd_s[1]), .write(wr_s[1]), .address(addr_s[1]),
    .byteenable(be_s[1]), .writedata(wd_s[1]), .waitrequest(wreq_s[1]),
    .readdata(rdata_s[1]), .fault(flt_s[1]), .dbg_state_o(st_s[1]));

  avalon_bus_ram #(.WAIT_CYCLES(4)) dut_w4 (
    .clk(clk), .reset(reset), .read(rd_s[2]), .write(wr_s[2]), .address(addr_s[2]),
    .byteenable(be_s[2]), .writedata(wd_s[2]), .waitrequest(wreq_s[2]),
    .readdata(rdata_s[2]), .fault(flt_s[2]), .dbg_state_o(st_s[2]));

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_flt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transfer on instance d; returns wait count, data and fault pulses.
  task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      output int waits, output logic [31:0] rdat, output int nflt);
    bit done;
    done  = 1'b0;
    waits = 0;
    nflt  = 0;
    rdat  = 32'd0;
    @(posedge clk); #1;
    rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; be_s[d] = be; wd_s[d] = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (flt_s[d]) nflt++;
      if (wreq_s[d]) waits++;
      else begin
        done = 1'b1;
        rdat = rdata_s[d];
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL xfer_timeout dut%0d: waitrequest still 1 after 40 cycles, expected 0", d);
    end
    @(posedge clk); #1;
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    @(negedge clk);
    if (flt_s[d]) nflt++;
  endtask

  initial begin
    int          waits, nflt, fc;
    logic [31:0] rdat;
    int          pat[6];

    // Transfer table for the 1-wait instance (image built by the writes).
    vecs[0]  = '{1'b0, 1'b1, B,             4'hF, 32'h78563412, 1'b0, 32'h0,        0};
    vecs[1]  = '{1'b1, 1'b0, B,             4'hF, 32'h0,        1'b1, 32'h78563412, 0};
    vecs[2]  = '{1'b0, 1'b1, B + 32'h4,     4'hF, 32'hA1B2C3D4, 1'b0, 32'h0,        0};
    vecs[3]  = '{1'b1, 1'b0, B + 32'h4,     4'h1, 32'h0,        1'b1, 32'h785634D4, 0};
    vecs[4]  = '{1'b1, 1'b0, B + 32'h4,     4'hC, 32'h0,        1'b1, 32'hA1B234D4, 0};
    vecs[5]  = '{1'b0, 1'b1, B + 32'h4,     4'h2, 32'h0000EE00, 1'b0, 32'h0,        0};
    vecs[6]  = '{1'b1, 1'b0, B + 32'h4,     4'hF, 32'h0,        1'b1, 32'hA1B2EED4, 0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         4'hF, 32'h0,        1'b1, 32'h0,        1};
    vecs[8]  = '{1'b1, 1'b0, B,             4'hF, 32'h0,        1'b1, 32'h78563412, 0};
    vecs[9]  = '{1'b1, 1'b0, B + 32'h2,     4'hF, 32'h0,        1'b1, 32'h0,        1};
    vecs[10] = '{1'b1, 1'b0, B,             4'h3, 32'h0,        1'b1, 32'h00003412, 0};
    vecs[11] = '{1'b0, 1'b1, B + 32'hFFC,   4'hF, 32'h11223344, 1'b0, 32'h0,        0};
    vecs[12] = '{1'b1, 1'b0, B + 32'hFFC,   4'hF, 32'h0,        1'b1, 32'h11223344, 0};
    vecs[13] = '{1'b1, 1'b0, B + 32'h1000,  4'hF, 32'h0,        1'b1, 32'h0,        1};
    vecs[14] = '{1'b1, 1'b0, 32'hBFBFFFFC,  4'hF, 32'h0,        1'b1, 32'h0,        1};
    vecs[15] = '{1'b1, 1'b1, B,             4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        1};
    vecs[16] = '{1'b0, 1'b1, 32'h0,         4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1};
    vecs[17] = '{1'b1, 1'b0, B,             4'hF, 32'h0,        1'b1, 32'h78563412, 0};

    // Clock/reset: hold reset with a pending read; waitrequest must stay low.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'd0; be_s[i] = 4'h0; wd_s[i] = 32'd0;
    end
    rd_s[0] = 1'b1; addr_s[0] = B; be_s[0] = 4'hF;
    #12;
    check("reset_waitreq", 32'(wreq_s[0]), 32'd0);
    check("reset_readdata", rdata_s[0], 32'd0);
    check("reset_fault", 32'(flt_s[0]), 32'd0);
    check("reset_state", 32'(st_s[0]), 32'(IDLE));
    rd_s[0] = 1'b0;
    #10;
    reset = 1'b0;

    // Table-driven single transfers, 1 wait state.
    for (int i = 0; i < 18; i++) begin
      xfer(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].be, vecs[i].wd, waits, rdat, nflt);
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'd1);
      check($sformatf("vec%0d_fault", i), 32'(nflt), 32'(vecs[i].exp_flt));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rd);
    end

    // 3 wait states: partial write keeps the upper lanes of the stored word.
    xfer(1, 1'b0, 1'b1, B + 32'h4, 4'hF, 32'h01020304, waits, rdat, nflt);
    check("w3_fill_waits", 32'(waits), 32'd3);
    xfer(1, 1'b0, 1'b1, B + 32'h4, 4'b0011, 32'hAABBCCDD, waits, rdat, nflt);
    check("w3_wr_waits", 32'(waits), 32'd3);
    check("w3_wr_fault", 32'(nflt), 32'd0);
    xfer(1, 1'b1, 1'b0, B + 32'h4, 4'hF, 32'h0, waits, rdat, nflt);
    check("w3_rd_waits", 32'(waits), 32'd3);
    check("w3_rd_data", rdat, 32'h0102CCDD);

    // 4 wait states: write dropped in its third wait cycle is abandoned.
    xfer(2, 1'b0, 1'b1, B + 32'h8, 4'hF, 32'h55667788, waits, rdat, nflt);
    check("w4_fill_waits", 32'(waits), 32'd4);
    fc = 0;
    @(posedge clk); #1;
    wr_s[2] = 1'b1; addr_s[2] = B + 32'h8; be_s[2] = 4'hF; wd_s[2] = 32'hFFFFFFFF;
    @(negedge clk);
    if (flt_s[2]) fc++;
    check("drop_c0_waitreq", 32'(wreq_s[2]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    if (flt_s[2]) fc++;
    check("drop_c1_waitreq", 32'(wreq_s[2]), 32'd1);
    @(posedge clk); #1;
    wr_s[2] = 1'b0;
    @(negedge clk);
    if (flt_s[2]) fc++;
    check("drop_c2_waitreq", 32'(wreq_s[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    if (flt_s[2]) fc++;
    check("drop_state_idle", 32'(st_s[2]), 32'(IDLE));
    check("drop_fault", 32'(fc), 32'd0);
    xfer(2, 1'b1, 1'b0, B + 32'h8, 4'hF, 32'h0, waits, rdat, nflt);
    check("drop_rd_waits", 32'(waits), 32'd4);
    check("drop_rd_data", rdat, 32'h55667788);

    // Reset in the middle of a write: bus freed at once, word untouched.
    @(posedge clk); #1;
    wr_s[2] = 1'b1; addr_s[2] = B + 32'h8; be_s[2] = 4'hF; wd_s[2] = 32'h0;
    @(negedge clk);
    check("rst_mid_pre_waitreq", 32'(wreq_s[2]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    check("rst_mid_waitreq", 32'(wreq_s[2]), 32'd0);
    check("rst_mid_state", 32'(st_s[2]), 32'(IDLE));
    wr_s[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_rdata_cleared", rdata_s[0], 32'd0);
    xfer(2, 1'b1, 1'b0, B + 32'h8, 4'hF, 32'h0, waits, rdat, nflt);
    check("rst_mid_rd_waits", 32'(waits), 32'd4);
    check("rst_mid_rd_data", rdat, 32'h55667788);

    // Read held across three transfers: each one pays the wait again.
    pat = '{1, 0, 1, 0, 1, 0};
    @(posedge clk); #1;
    rd_s[0] = 1'b1; addr_s[0] = B; be_s[0] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d_waitreq", i), 32'(wreq_s[0]), 32'(pat[i]));
      if (pat[i] == 0) check($sformatf("b2b_c%0d_rdata", i), rdata_s[0], 32'h78563412);
    end
    @(posedge clk); #1;
    rd_s[0] = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "time limit reached");
  end

endmodule
